// File: rtl/tick_sched_ctrl_if.sv
// Increment-configuration channel for tick_sched_ctrl: a valid/ready transfer of a new
// phase-accumulator increment.
interface tick_sched_ctrl_if #(
    parameter int ACC_W = 32
) ();
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_valid;
    logic             cfg_ready;

    modport master (output cfg_inc, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_inc, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/tick_sched_ctrl.sv
// Phase-accumulator tick scheduler: emits tick_en pulses and a divided square wave,
// optionally for a fixed burst of ticks, with glitch-free increment updates at period boundaries.
module tick_sched_ctrl #(
    parameter int               ACC_W       = 32,
    parameter int               CNT_W       = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 32'h0100_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_sched_ctrl_if.slave     cfg,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [CNT_W-1:0]     i_burst_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_tick_en,
    output logic                 o_tick_clk,
    output logic [CNT_W-1:0]     o_tick_cnt
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [ACC_W-1:0] r_acc, w_acc_next;
    logic [ACC_W-1:0] r_inc, w_inc_next;
    logic [ACC_W-1:0] r_pend, w_pend_next;
    logic             r_ready, w_ready_next;
    logic             r_phase_d, w_phase_next;
    logic             r_tick_en, w_tick_en_next;
    logic             r_tick_clk, w_tick_clk_next;
    logic             r_done, w_done_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_blen, w_blen_next;

    logic             w_msb, w_tick, w_apply, w_xfer;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_inc_eff;

    assign w_msb     = r_acc[ACC_W-1];
    assign w_tick    = w_msb & ~r_phase_d;
    assign w_xfer    = cfg.cfg_valid & r_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_inc_next      = r_inc;
        w_pend_next     = r_pend;
        w_ready_next    = r_ready;
        w_phase_next    = r_phase_d;
        w_tick_en_next  = 1'b0;
        w_tick_clk_next = 1'b0;
        w_done_next     = 1'b0;
        w_cnt_next      = r_cnt;
        w_blen_next     = r_blen;
        w_apply         = 1'b0;
        w_inc_eff       = r_inc;

        case (r_state)
            S_IDLE: begin
                w_apply = ~r_ready;
                if (i_start) begin
                    w_state_next = S_RUN;
                    w_acc_next   = '0;
                    w_phase_next = 1'b0;
                    w_cnt_next   = '0;
                    w_blen_next  = i_burst_len;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    // A pending increment already drives the add on the boundary edge,
                    // so the very next period runs entirely at the new rate.
                    w_apply        = w_tick & ~r_ready;
                    w_inc_eff      = w_apply ? r_pend : r_inc;
                    w_acc_next     = r_acc + w_inc_eff;
                    w_phase_next   = w_msb;
                    w_tick_en_next = w_tick;
                    if (w_tick) begin
                        w_cnt_next = w_cnt_inc;
                        if ((r_blen != '0) && (w_cnt_inc == r_blen)) begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                    w_tick_clk_next = (w_state_next == S_RUN) ? w_msb : 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_apply) begin
            w_inc_next   = r_pend;
            w_pend_next  = '0;
            w_ready_next = 1'b1;
        end
        if (w_xfer) begin
            w_pend_next  = cfg.cfg_inc;
            w_ready_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_inc      <= DEFAULT_INC;
            r_pend     <= '0;
            r_ready    <= 1'b1;
            r_phase_d  <= 1'b0;
            r_tick_en  <= 1'b0;
            r_tick_clk <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_blen     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_inc      <= w_inc_next;
            r_pend     <= w_pend_next;
            r_ready    <= w_ready_next;
            r_phase_d  <= w_phase_next;
            r_tick_en  <= w_tick_en_next;
            r_tick_clk <= w_tick_clk_next;
            r_done     <= w_done_next;
            r_cnt      <= w_cnt_next;
            r_blen     <= w_blen_next;
        end
    end

    assign cfg.cfg_ready = r_ready;
    assign o_busy        = (r_state == S_RUN);
    assign o_done        = r_done;
    assign o_tick_en     = r_tick_en;
    assign o_tick_clk    = r_tick_clk;
    assign o_tick_cnt    = r_cnt;
endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Bench for tick_sched_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural reference model.
module tb_tick_sched_ctrl;
    localparam int          ACC_W   = 32;
    localparam int          CNT_W   = 8;
    localparam logic [31:0] DEF_INC = 32'h0100_0000;
    localparam bit   [31:0] HALF    = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             busy, done, tick_en, tick_clk;
    logic [CNT_W-1:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    tick_sched_ctrl_if #(.ACC_W(ACC_W)) cfg_if ();

    tick_sched_ctrl #(
        .ACC_W       (ACC_W),
        .CNT_W       (CNT_W),
        .DEFAULT_INC (DEF_INC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if.slave),
        .i_start     (start),
        .i_stop      (stop),
        .i_burst_len (burst_len),
        .o_busy      (busy),
        .o_done      (done),
        .o_tick_en   (tick_en),
        .o_tick_clk  (tick_clk),
        .o_tick_cnt  (tick_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a running flag, an arithmetic phase value and the last seen
    // MSB; a tick is any rising MSB, a pending increment swaps in at a tick.
    bit          m_run, m_prev_msb, m_ten, m_tclk, m_done, m_has_pend;
    bit   [31:0] m_phase, m_rate, m_pend_rate;
    int          m_ticks, m_burst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit take, now_high;
        take = cfg_if.cfg_valid && !m_has_pend;
        m_ten  = 0;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_prev_msb = 0; m_tclk = 0; m_has_pend = 0;
            m_phase = 0; m_rate = DEF_INC; m_pend_rate = 0; m_ticks = 0; m_burst = 0;
            return;
        end
        if (!m_run) begin
            m_tclk = 0;
            if (m_has_pend) begin
                m_rate = m_pend_rate;
                m_has_pend = 0;
            end
            if (start) begin
                m_run = 1; m_phase = 0; m_prev_msb = 0; m_ticks = 0;
                m_burst = int'(burst_len);
            end
        end else if (stop) begin
            m_run = 0; m_done = 1; m_tclk = 0;
        end else begin
            now_high = (m_phase >= HALF);
            m_ten = now_high && !m_prev_msb;
            if (m_ten && m_has_pend) begin
                m_rate = m_pend_rate;
                m_has_pend = 0;
            end
            m_phase    = m_phase + m_rate;
            m_prev_msb = now_high;
            if (m_ten) begin
                m_ticks = (m_ticks + 1) % (1 << CNT_W);
                if (m_burst != 0 && m_ticks == m_burst) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
            m_tclk = m_run ? m_prev_msb : 1'b0;
        end
        if (take) begin
            m_has_pend = 1;
            m_pend_rate = cfg_if.cfg_inc;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("tick_en", tick_en, m_ten);
        chk("tick_clk", tick_clk, m_tclk);
        chk("tick_cnt", tick_cnt, m_ticks);
        chk("cfg_ready", cfg_if.cfg_ready, !m_has_pend);
    endtask

    int tick_q[$];
    int done_q[$];

    task automatic watch(input int n);
        tick_q.delete();
        done_q.delete();
        for (int k = 1; k <= n; k++) begin
            cycle();
            if (tick_en) tick_q.push_back(k);
            if (done) done_q.push_back(k);
        end
    endtask

    task automatic load_inc(input logic [31:0] v);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_inc   = v;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        cycle();
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] bl);
        start = 1'b1;
        burst_len = bl;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    initial begin
        int busy_drops;
        logic [31:0] pick [7];
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_inc   = '0;

        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_cnt", tick_cnt, 0);

        // Burst of 3 at quarter rate: ticks every 4 edges, done on the last one.
        load_inc(32'h4000_0000);
        pulse_start(8'd3);
        watch(14);
        chk("b3_nticks", tick_q.size(), 3);
        if (tick_q.size() == 3) begin
            chk("b3_first", tick_q[0], 3);
            chk("b3_second", tick_q[1], 7);
            chk("b3_third", tick_q[2], 11);
        end
        chk("b3_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("b3_done_at", done_q[0], 11);
        chk("b3_cnt", tick_cnt, 3);
        chk("b3_busy", busy, 0);

        // Continuous run, rate change requested mid-period.
        pulse_start(8'd0);
        watch(5);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_inc   = HALF;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        chk("sw_ready_low", cfg_if.cfg_ready, 0);
        cycle();
        chk("sw_boundary_tick", tick_en, 1);
        chk("sw_ready_back", cfg_if.cfg_ready, 1);
        watch(6);
        chk("sw_nticks", tick_q.size(), 3);
        if (tick_q.size() == 3) begin
            chk("sw_first_gap", tick_q[0], 2);
            chk("sw_gap", tick_q[2] - tick_q[1], 2);
        end

        // Stop exactly on the edge that would have produced the third tick.
        pulse_stop();
        load_inc(32'h4000_0000);
        pulse_start(8'd0);
        watch(10);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_tick", tick_en, 0);
        chk("stop_done", done, 1);
        chk("stop_busy", busy, 0);
        chk("stop_cnt", tick_cnt, 2);
        cycle();
        chk("stop_done_clr", done, 0);

        // Continuous half-rate run wraps the tick counter without ending.
        load_inc(HALF);
        pulse_start(8'd0);
        busy_drops = 0;
        for (int k = 0; k < 2 * ((1 << CNT_W) + 2); k++) begin
            cycle();
            if (!busy) busy_drops++;
        end
        chk("wrap_cnt", tick_cnt, 2);
        chk("wrap_busy_drops", busy_drops, 0);

        // Reset in the middle of a burst.
        pulse_stop();
        pulse_start(8'd5);
        watch(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_tick_en", tick_en, 0);
        chk("mrst_tick_clk", tick_clk, 0);
        chk("mrst_cnt", tick_cnt, 0);
        chk("mrst_ready", cfg_if.cfg_ready, 1);
        cycle();
        chk("mrst_no_done", done, 0);
        pulse_start(8'd0);
        watch(130);
        chk("def_nticks", tick_q.size(), 1);
        if (tick_q.size() >= 1) chk("def_first", tick_q[0], 129);

        // Start and stop together in IDLE; then start while running.
        pulse_stop();
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 1);
        watch(300);
        pulse_start(8'd1);
        watch(20);
        chk("rs_busy", busy, 1);

        pick[0] = 32'h0;
        pick[1] = 32'h4000_0000;
        pick[2] = HALF;
        pick[3] = 32'hC000_0000;
        pick[4] = 32'h2000_0000;
        pick[5] = 32'h0800_0000;
        pick[6] = 32'h1000_0000;
        for (int k = 0; k < 5000; k++) begin
            rst   = ($urandom_range(0, 799) == 0);
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            burst_len = CNT_W'($urandom_range(0, 6));
            cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_if.cfg_inc = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : pick[$urandom_range(0, 6)];
            cycle();
        end
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_if.cfg_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tick_sched_ctrl.md
TICK_SCHED_CTRL -- requirements
Module: tick_sched_ctrl

Interface
REQ-001 Parameter ACC_W, 32, phase-accumulator width.
REQ-002 Parameter CNT_W, 16, burst-length and tick-counter width.
REQ-003 Parameter DEFAULT_INC, 32'h0100_0000, active increment loaded at reset.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_inc  input  ACC_W  new accumulator increment.
REQ-007 cfg_valid  input  1  cfg_inc offered.
REQ-008 cfg_ready  output  1  controller can accept cfg_inc.
REQ-009 start  input  1  begin tick generation (level sampled each cycle).
REQ-010 stop  input  1  abort tick generation.
REQ-011 burst_len  input  CNT_W  ticks to emit; 0 = continuous.
REQ-012 busy  output  1  controller in RUN.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 tick_en  output  1  one-cycle enable pulse per divided period.
REQ-015 tick_clk  output  1  divided square wave.
REQ-016 tick_cnt  output  CNT_W  ticks emitted in current/last run.

Function
REQ-017 Two states: IDLE, RUN; busy SHALL be 1 exactly when state is RUN; all outputs registered.
REQ-018 Config handshake: transfer when cfg_valid and cfg_ready both 1; cfg_inc captured into a pending register, cfg_ready then 0 until the pending value is applied; cfg_ready 1 on the cycle after application.
REQ-019 Pending application: in IDLE, applied to active increment on the next edge; in RUN, applied only on the edge that sets tick_en (period boundary), never mid-period.
REQ-020 IDLE + start: on that edge accumulator cleared to 0, phase_d cleared, tick_cnt cleared, burst_len latched, state to RUN; a pending increment is applied on the same edge.
REQ-021 RUN: accumulator <= accumulator + active increment each edge, modulo 2^ACC_W (wrap silently).
REQ-022 phase_d <= accumulator MSB each edge in RUN; tick_clk = phase_d in RUN, 0 in IDLE.
REQ-023 tick_en <= MSB & ~phase_d in RUN; tick_cnt increments (mod 2^CNT_W) on the same edge tick_en is set.
REQ-024 Latency: with increment 2^30, first tick_en is high in the cycle after the 3rd edge following start; period = 2^ACC_W / increment cycles when exact.
REQ-025 Increment 0 in RUN: no ticks; run ends only by stop.
REQ-026 Increment >= 2^(ACC_W-1): tick on every MSB rising edge (aliased rate), legal, no error.
REQ-027 Burst end: on the edge setting tick_en where tick_cnt+1 == latched burst_len (burst_len != 0), state to IDLE and done set on the same edge (done coincident with last tick_en).
REQ-028 stop in RUN: state to IDLE and done set next edge; stop has priority over a tick on that edge (no tick_en, tick_cnt not incremented, pending not applied).
REQ-029 start in RUN ignored; stop in IDLE ignored; start and stop together in IDLE: start wins.
REQ-030 IDLE: accumulator, tick_cnt held; tick_en and tick_clk 0; burst_len changes have no effect until next start.
REQ-031 Continuous mode: tick_cnt wraps 2^CNT_W-1 -> 0 without ending the run.

Reset
REQ-032 On rst: state IDLE, accumulator 0, phase_d 0, tick_en 0, tick_clk 0, done 0, busy 0, tick_cnt 0, pending cleared, cfg_ready 1, active increment DEFAULT_INC.
REQ-033 rst in RUN aborts immediately; no done pulse generated.
REQ-034 rst dominates all other inputs on the same edge.

Verification
REQ-035 Config 0x4000_0000 in IDLE, start, burst_len=3 -> tick_en pulses every 4 cycles, first after 3rd edge post-start; done with 3rd tick; tick_cnt=3; busy 0 afterwards.
REQ-036 RUN continuous at 0x4000_0000, load 0x8000_0000 mid-period -> cfg_ready 0 until next tick_en; subsequent tick spacing 2 cycles, no shortened/lengthened period at switch.
REQ-037 stop asserted on the cycle a tick would be set -> no tick_en, tick_cnt unchanged, done 1 for one cycle, state IDLE.
REQ-038 Continuous run with increment 0x8000_0000 for 2^16+2 ticks -> tick_cnt wraps to 0 and reaches 2, busy stays 1.
REQ-039 rst mid-burst -> all outputs to REQ-032 values next cycle, no done; increment back to DEFAULT_INC.
REQ-040 start+stop same cycle in IDLE -> RUN entered; start during RUN -> accumulator and tick_cnt undisturbed.
